// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl: gates the MIPS pipeline enable.
// Handles the power-up hold-off, continuous run, single-step and run-N modes,
// and halts on a PC breakpoint, a halt instruction or an external request.
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   mode, start, step   - run mode select, run start/resume pulse, step pulse
//   halt_req, clear     - external halt level, return-to-idle from HALT
//   run_count           - enabled-cycle budget for run-N, sampled on start
//   pc_in, instr_in     - IF-stage incremented PC and instruction
//   bp_addr, bp_en      - flat breakpoint address table and enables
//   ena                 - registered pipeline enable
//   cycle_count         - count of enabled cycles (wraps)
//   state, halted       - current state, high while in HALT
//   halt_cause, done    - latched halt reason, one-cycle pulse on HALT entry
module pipeline_run_ctrl #(
    parameter int                    PC_WIDTH  = 32,
    parameter int                    CNT_WIDTH = 32,
    parameter int                    HOLDOFF   = 500,
    parameter int                    NUM_BP    = 2,
    parameter logic [PC_WIDTH-1:0]   HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 mode,
    input  logic                       start,
    input  logic                       step,
    input  logic                       halt_req,
    input  logic                       clear,
    input  logic [CNT_WIDTH-1:0]       run_count,
    input  logic [PC_WIDTH-1:0]        pc_in,
    input  logic [PC_WIDTH-1:0]        instr_in,
    input  logic [NUM_BP*PC_WIDTH-1:0] bp_addr,
    input  logic [NUM_BP-1:0]          bp_en,
    output logic                       ena,
    output logic [CNT_WIDTH-1:0]       cycle_count,
    output logic [2:0]                 state,
    output logic                       halted,
    output logic [2:0]                 halt_cause,
    output logic                       done
);

    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic [2:0] {
        S_HOLDOFF = 3'd0,
        S_IDLE    = 3'd1,
        S_RUN     = 3'd2,
        S_STEP    = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [2:0] CAUSE_NONE  = 3'd0;
    localparam logic [2:0] CAUSE_EXT   = 3'd1;
    localparam logic [2:0] CAUSE_BP    = 3'd2;
    localparam logic [2:0] CAUSE_INSTR = 3'd3;
    localparam logic [2:0] CAUSE_COUNT = 3'd4;

    state_t               state_q, state_d;
    logic                 ena_q, ena_d;
    logic                 halted_q, halted_d;
    logic                 done_q, done_d;
    logic [2:0]           cause_q, cause_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] rem_q, rem_d;
    logic                 run_n_q, run_n_d;
    logic                 bp_skip_q, bp_skip_d;
    logic [HW-1:0]        hold_q, hold_d;

    logic       bp_hit_s;
    logic       start_ok_s;
    state_t     launch_state_s;
    logic [2:0] run_cause_s;
    logic [2:0] step_cause_s;

    // Decode breakpoint hit, start legality and halt causes for the current cycle.
    always_comb begin
        bp_hit_s = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            bp_hit_s = bp_hit_s | (bp_en[i] & (pc_in == bp_addr[i*PC_WIDTH +: PC_WIDTH]));
        end

        // Mode 11 and a zero-length run-N are not legal starts.
        start_ok_s = start & ((mode == 2'b00) | (mode == 2'b01) |
                              ((mode == 2'b10) & (run_count != {CNT_WIDTH{1'b0}})));
        launch_state_s = (mode == 2'b01) ? S_STEP : S_RUN;

        if (halt_req) begin
            run_cause_s = CAUSE_EXT;
        end else if (bp_hit_s && !bp_skip_q) begin
            run_cause_s = CAUSE_BP;
        end else if (instr_in == HALT_WORD) begin
            run_cause_s = CAUSE_INSTR;
        end else if (run_n_q && (rem_q == CNT_WIDTH'(1))) begin
            run_cause_s = CAUSE_COUNT;
        end else begin
            run_cause_s = CAUSE_NONE;
        end

        // Breakpoints play no part while single-stepping.
        if (halt_req) begin
            step_cause_s = CAUSE_EXT;
        end else if (instr_in == HALT_WORD) begin
            step_cause_s = CAUSE_INSTR;
        end else begin
            step_cause_s = CAUSE_NONE;
        end
    end

    // Next-state and next-output computation for the run sequencer.
    always_comb begin
        state_d   = state_q;
        ena_d     = ena_q;
        halted_d  = halted_q;
        done_d    = 1'b0;
        cause_d   = cause_q;
        count_d   = ena_q ? (count_q + CNT_WIDTH'(1)) : count_q;
        rem_d     = rem_q;
        run_n_d   = run_n_q;
        bp_skip_d = bp_skip_q;
        hold_d    = hold_q;

        case (state_q)
            S_HOLDOFF: begin
                ena_d = 1'b0;
                if (hold_q <= HW'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLDOFF;
                end
                if (hold_q != HW'(0)) begin
                    hold_d = hold_q - HW'(1);
                end else begin
                    hold_d = hold_q;
                end
            end
            S_IDLE: begin
                if (start_ok_s && !halt_req) begin
                    state_d = launch_state_s;
                    ena_d   = (mode != 2'b01);
                    run_n_d = (mode == 2'b10);
                    rem_d   = run_count;
                end else begin
                    ena_d = 1'b0;
                end
            end
            S_RUN: begin
                bp_skip_d = 1'b0;
                if (run_cause_s != CAUSE_NONE) begin
                    state_d  = S_HALT;
                    ena_d    = 1'b0;
                    halted_d = 1'b1;
                    done_d   = 1'b1;
                    cause_d  = run_cause_s;
                end else if (run_n_q) begin
                    rem_d = rem_q - CNT_WIDTH'(1);
                end else begin
                    rem_d = rem_q;
                end
            end
            S_STEP: begin
                if (ena_q) begin
                    // Enabled cycle: any step pulse here is dropped.
                    bp_skip_d = 1'b0;
                    ena_d     = 1'b0;
                    if (step_cause_s != CAUSE_NONE) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        done_d   = 1'b1;
                        cause_d  = step_cause_s;
                    end else begin
                        state_d = S_STEP;
                    end
                end else if (step) begin
                    ena_d = 1'b1;
                end else begin
                    ena_d = 1'b0;
                end
            end
            S_HALT: begin
                ena_d = 1'b0;
                if (clear) begin
                    state_d  = S_IDLE;
                    halted_d = 1'b0;
                    cause_d  = CAUSE_NONE;
                    count_d  = {CNT_WIDTH{1'b0}};
                end else if (start_ok_s) begin
                    // Skip the breakpoint compare once so a run can leave a breakpoint PC.
                    state_d   = launch_state_s;
                    ena_d     = (mode != 2'b01);
                    run_n_d   = (mode == 2'b10);
                    rem_d     = run_count;
                    halted_d  = 1'b0;
                    bp_skip_d = 1'b1;
                end else begin
                    state_d = S_HALT;
                end
            end
            default: begin
                state_d  = S_IDLE;
                ena_d    = 1'b0;
                halted_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops ena immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_HOLDOFF;
            ena_q     <= 1'b0;
            halted_q  <= 1'b0;
            done_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
            count_q   <= {CNT_WIDTH{1'b0}};
            rem_q     <= {CNT_WIDTH{1'b0}};
            run_n_q   <= 1'b0;
            bp_skip_q <= 1'b0;
            hold_q    <= HW'(HOLDOFF);
        end else begin
            state_q   <= state_d;
            ena_q     <= ena_d;
            halted_q  <= halted_d;
            done_q    <= done_d;
            cause_q   <= cause_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            run_n_q   <= run_n_d;
            bp_skip_q <= bp_skip_d;
            hold_q    <= hold_d;
        end
    end

    assign ena         = ena_q;
    assign cycle_count = count_q;
    assign state       = state_q;
    assign halted      = halted_q;
    assign halt_cause  = cause_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Self-checking bench for pipeline_run_ctrl: directed scenarios plus a
// randomized phase, all outputs compared every cycle against a behavioural model.
module tb_pipeline_run_ctrl;

    localparam int          PW = 32;
    localparam int          CW = 32;
    localparam int          HO = 4;
    localparam int          NB = 2;
    localparam logic [31:0] HWORD = 32'hFFFF_FFFF;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [1:0]     mode = 2'd0;
    logic           start = 1'b0, step = 1'b0, halt_req = 1'b0, clear = 1'b0;
    logic [CW-1:0]  run_count = '0;
    logic [PW-1:0]  pc_in = '0, instr_in = '0;
    logic [NB*PW-1:0] bp_addr = '0;
    logic [NB-1:0]  bp_en = '0;
    logic           ena, halted, done;
    logic [CW-1:0]  cycle_count;
    logic [2:0]     state, halt_cause;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_run_ctrl #(.PC_WIDTH(PW), .CNT_WIDTH(CW), .HOLDOFF(HO), .NUM_BP(NB), .HALT_WORD(HWORD)) dut (
        .clk(clk), .reset(reset), .mode(mode), .start(start), .step(step),
        .halt_req(halt_req), .clear(clear), .run_count(run_count), .pc_in(pc_in),
        .instr_in(instr_in), .bp_addr(bp_addr), .bp_en(bp_en), .ena(ena),
        .cycle_count(cycle_count), .state(state), .halted(halted),
        .halt_cause(halt_cause), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: named states 0..4, causes 0..4, as in the interface description.
    int          m_state, m_cause, m_hold;
    bit          m_ena, m_halted, m_done, m_run_n, m_skip;
    logic [31:0] m_cnt, m_rem;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_hold = HO; m_cause = 0; m_cnt = '0; m_rem = '0;
        m_ena = 0; m_halted = 0; m_done = 0; m_run_n = 0; m_skip = 0;
    endtask

    function automatic bit launch_ok();
        if (!start || mode == 2'd3) return 0;
        if (mode == 2'd2 && run_count == '0) return 0;
        return 1;
    endfunction

    function automatic bit bp_match();
        bit hit = 0;
        for (int i = 0; i < NB; i++)
            if (bp_en[i] && pc_in == bp_addr[i*PW +: PW]) hit = 1;
        return hit;
    endfunction

    task automatic model_launch();
        m_state = (mode == 2'd1) ? 3 : 2;
        m_ena   = (mode != 2'd1);
        m_run_n = (mode == 2'd2);
        m_rem   = run_count;
    endtask

    task automatic model_halt(input int c);
        m_state = 4; m_ena = 0; m_halted = 1; m_done = 1; m_cause = c;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
            return;
        end
        if (m_ena) m_cnt = m_cnt + 32'd1;
        m_done = 0;
        case (m_state)
            0: begin
                if (m_hold <= 1) m_state = 1;
                if (m_hold > 0) m_hold--;
            end
            1: if (!halt_req && launch_ok()) model_launch();
            2: begin
                if (halt_req) model_halt(1);
                else if (bp_match() && !m_skip) model_halt(2);
                else if (instr_in == HWORD) model_halt(3);
                else if (m_run_n && m_rem == 32'd1) model_halt(4);
                else m_rem = m_rem - 32'd1;
                m_skip = 0;
            end
            3: begin
                if (m_ena) begin
                    m_skip = 0;
                    if (halt_req) model_halt(1);
                    else if (instr_in == HWORD) model_halt(3);
                    else m_ena = 0;
                end else if (step) m_ena = 1;
            end
            4: begin
                if (clear) begin
                    m_state = 1; m_halted = 0; m_cause = 0; m_cnt = '0;
                end else if (launch_ok()) begin
                    model_launch(); m_halted = 0; m_skip = 1;
                end
            end
            default: m_state = 1;
        endcase
    endtask

    task automatic compare_all();
        check_eq("ena",         64'(ena),         64'(m_ena));
        check_eq("state",       64'(state),       64'(m_state));
        check_eq("cycle_count", 64'(cycle_count), 64'(m_cnt));
        check_eq("halted",      64'(halted),      64'(m_halted));
        check_eq("halt_cause",  64'(halt_cause),  64'(m_cause));
        check_eq("done",        64'(done),        64'(m_done));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        int ena_seen, done_seen;
        model_reset();
        tick(); tick();

        // Hold-off: state 0 for four cycles, then IDLE.
        reset = 1'b0;
        check_eq("rst_cycle_count", 64'(cycle_count), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("holdoff_state", 64'(state), 64'd0);
            check_eq("holdoff_ena", 64'(ena), 64'd0);
        end
        tick();
        check_eq("holdoff_done_idle", 64'(state), 64'd1);

        // Run-N with run_count = 5.
        mode = 2'd2; run_count = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        ena_seen = ena ? 1 : 0; done_seen = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (ena) ena_seen++;
            if (done) done_seen++;
        end
        check_eq("runn_ena_cycles", 64'(ena_seen), 64'd5);
        check_eq("runn_count", 64'(cycle_count), 64'd5);
        check_eq("runn_cause", 64'(halt_cause), 64'd4);
        check_eq("runn_done_pulses", 64'(done_seen), 64'd1);

        // Breakpoint halt and resume off the breakpoint PC.
        clear = 1'b1; tick(); clear = 1'b0;
        bp_addr = {32'h0000_0010, 32'h0000_0100}; bp_en = 2'b10;
        mode = 2'd0; start = 1'b1; tick(); start = 1'b0;
        pc_in = 32'h4; tick();
        pc_in = 32'h8; tick();
        pc_in = 32'hC; tick();
        check_eq("bp_still_run", 64'(state), 64'd2);
        pc_in = 32'h10; tick();
        check_eq("bp_halted", 64'(halted), 64'd1);
        check_eq("bp_cause", 64'(halt_cause), 64'd2);
        start = 1'b1; tick(); start = 1'b0;
        check_eq("bp_resume_ena", 64'(ena), 64'd1);
        tick();
        check_eq("bp_resume_no_halt", 64'(state), 64'd2);
        tick();
        check_eq("bp_second_hit", 64'(halt_cause), 64'd2);

        // Single-step: three pulses, breakpoint PC ignored.
        clear = 1'b1; tick(); clear = 1'b0;
        mode = 2'd1; start = 1'b1; tick(); start = 1'b0;
        check_eq("step_wait_ena", 64'(ena), 64'd0);
        pc_in = 32'h10; bp_en = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; tick(); step = 1'b0;
            check_eq("step_pulse", 64'(ena), 64'd1);
            tick();
            check_eq("step_after", 64'(ena), 64'd0);
            tick(); tick();
        end
        check_eq("step_count", 64'(cycle_count), 64'd3);
        check_eq("step_state", 64'(state), 64'd3);
        step = 1'b1; tick(); step = 1'b0;
        instr_in = HWORD; tick(); instr_in = '0;
        check_eq("step_instr_cause", 64'(halt_cause), 64'd3);

        // External request outranks halt instruction; clear returns to IDLE.
        clear = 1'b1; tick(); clear = 1'b0;
        mode = 2'd0; start = 1'b1; tick(); start = 1'b0;
        instr_in = HWORD; halt_req = 1'b1; tick();
        instr_in = '0; halt_req = 1'b0;
        check_eq("ext_cause", 64'(halt_cause), 64'd1);
        clear = 1'b1; tick(); clear = 1'b0;
        check_eq("clear_state", 64'(state), 64'd1);
        check_eq("clear_count", 64'(cycle_count), 64'd0);
        check_eq("clear_cause", 64'(halt_cause), 64'd0);

        // Randomized phase against the model.
        bp_addr = {32'h0000_0010, 32'h0000_0020};
        for (int i = 0; i < 600; i++) begin
            mode      = 2'($urandom_range(0, 3));
            start     = ($urandom % 4) == 0;
            step      = ($urandom % 3) == 0;
            halt_req  = ($urandom % 20) == 0;
            clear     = ($urandom % 8) == 0;
            run_count = 32'($urandom_range(0, 6));
            bp_en     = 2'($urandom_range(0, 3));
            case ($urandom % 4)
                0: pc_in = 32'h10;
                1: pc_in = 32'h20;
                default: pc_in = $urandom;
            endcase
            instr_in = (($urandom % 12) == 0) ? HWORD : $urandom;
            tick();
        end
        start = 1'b0; step = 1'b0; halt_req = 1'b0; clear = 1'b0; instr_in = '0;

        // Reset asserted mid-run.
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < HO; i++) tick();
        mode = 2'd0; start = 1'b1; tick(); start = 1'b0;
        pc_in = 32'h4; tick();
        check_eq("mid_run_ena", 64'(ena), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_ena_drop", 64'(ena), 64'd0);
        check_eq("async_state", 64'(state), 64'd0);
        check_eq("async_count", 64'(cycle_count), 64'd0);
        model_reset();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("holdoff_restart", 64'(state), 64'd0);
        end
        tick();
        check_eq("holdoff_restart_idle", 64'(state), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
